// File: rtl/fifo_rr_drain.sv
// Round-robin drain scheduler: grants one of NQ source FIFOs at a time for bursts of
// up to BURST pops, and registers each popped word onto a valid/ready stage tagged with its queue ID.
module fifo_rr_drain #(
    parameter int NQ    = 4,
    parameter int DW    = 24,
    parameter int BURST = 4,
    parameter int QW    = $clog2(NQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NQ-1:0]    q_en,
    input  logic [NQ-1:0]    q_vld,
    input  logic [NQ*DW-1:0] q_data,
    output logic [NQ-1:0]    q_pop,
    output logic             out_vld,
    output logic [DW-1:0]    out_data,
    output logic [QW-1:0]    out_qid,
    input  logic             out_rdy,
    output logic             busy
);

    localparam int BCW = $clog2(BURST + 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST - 1);
    localparam logic [QW-1:0]  LAST_Q     = QW'(NQ - 1);

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    state_t         state, state_nxt;
    logic [QW-1:0]  cur, ptr, cur_inc;
    logic [BCW-1:0] burst_cnt;
    logic [NQ-1:0]  elig;
    logic [DW-1:0]  q_word [NQ];
    logic [QW-1:0]  winner, hi_idx, lo_idx;
    logic           hi_hit, lo_hit, win_vld;
    logic           cur_ok, can_load, pop, serve_exit;

    always_comb begin
        for (int unsigned i = 0; i < NQ; i++) begin
            q_word[i] = q_data[i*DW +: DW];
        end
    end

    assign elig = q_vld & q_en;

    // Rotating priority from ptr: the lowest eligible index at or above ptr wins,
    // otherwise the lowest eligible index below it. Wraps at NQ, not at 2**QW.
    always_comb begin
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int unsigned i = NQ; i > 0; i--) begin
            if (elig[i-1]) begin
                if ((i - 1) >= 32'(ptr)) begin
                    hi_hit = 1'b1;
                    hi_idx = QW'(i - 1);
                end else begin
                    lo_hit = 1'b1;
                    lo_idx = QW'(i - 1);
                end
            end
        end
        win_vld = hi_hit | lo_hit;
        winner  = hi_hit ? hi_idx : lo_idx;
    end

    assign cur_ok     = q_vld[cur] && q_en[cur];
    assign can_load   = !out_vld || out_rdy;
    assign pop        = (state == SERVE) && can_load && cur_ok;
    assign serve_exit = !cur_ok || (pop && (burst_cnt == BURST_LAST));
    assign cur_inc    = (cur == LAST_Q) ? '0 : cur + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld)    state_nxt = SERVE;
            SERVE:   if (serve_exit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        q_pop = '0;
        if (rst_n && pop) begin
            q_pop[cur] = 1'b1;
        end
        busy = (state == SERVE);
    end

    // A load and a downstream accept may share a cycle, so load takes priority over clearing out_vld.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            out_qid   <= '0;
        end else begin
            if (state == IDLE && win_vld) begin
                cur       <= winner;
                burst_cnt <= '0;
            end
            if (state == SERVE && serve_exit) begin
                ptr <= cur_inc;
            end
            if (pop) begin
                out_data  <= q_word[cur];
                out_qid   <= cur;
                out_vld   <= 1'b1;
                burst_cnt <= burst_cnt + 1'b1;
            end else if (out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: bench-modelled source FIFOs, a scoreboard of popped words,
// a table of arbitration scenarios and hand-written multi-cycle sequences.
module tb_fifo_rr_drain;

    localparam int NQ    = 4;
    localparam int DW    = 24;
    localparam int BURST = 4;
    localparam int QW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NQ-1:0]    q_en, q_vld, q_pop;
    logic [NQ*DW-1:0] q_data;
    logic             out_vld, out_rdy, busy;
    logic [DW-1:0]    out_data;
    logic [QW-1:0]    out_qid;

    fifo_rr_drain #(.NQ(NQ), .DW(DW), .BURST(BURST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .q_en     (q_en),
        .q_vld    (q_vld),
        .q_data   (q_data),
        .q_pop    (q_pop),
        .out_vld  (out_vld),
        .out_data (out_data),
        .out_qid  (out_qid),
        .out_rdy  (out_rdy),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [QW-1:0] qid;
    } item_t;

    // Scenario: enables, words per source queue, expected qid order (hex nibbles, first on the left).
    typedef struct packed {
        logic [3:0]      en;
        logic [3:0][7:0] nw;
        logic [7:0]      n;
        logic [7:0]      gapchk;
        logic [95:0]     exp;
    } tv_t;

    int              checks = 0;
    int              errors = 0;
    logic [NQ-1:0]   en_r;
    int unsigned     cnt [NQ];
    int unsigned     pos [NQ];
    int unsigned     popcnt [NQ];
    logic [7:0]      tag;
    item_t           sb [$];
    logic [QW-1:0]   oq [$];
    int unsigned     ocyc [$];
    int unsigned     cyc;
    logic [NQ-1:0]   last_pop;
    tv_t             tv [4];

    function automatic logic [DW-1:0] mkword(input int unsigned q, input int unsigned p);
        return {tag, 8'(q), 8'(p)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic step(input logic rdy);
        item_t it;
        for (int i = 0; i < NQ; i++) begin
            q_vld[i]           = (cnt[i] != 0);
            q_data[i*DW +: DW] = mkword(i, pos[i]);
        end
        q_en    = en_r;
        out_rdy = rdy;
        #1;
        last_pop = q_pop;
        chk("pop_onehot0", 32'($countones(q_pop) <= 1), 1);
        if (out_vld && out_rdy) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk("out_data", out_data, it.data);
                chk("out_qid", out_qid, it.qid);
                oq.push_back(out_qid);
                ocyc.push_back(cyc);
            end
        end
        for (int i = 0; i < NQ; i++) begin
            if (q_pop[i]) begin
                chk("pop_legal", 32'(q_vld[i] && q_en[i]), 1);
                if (q_vld[i] && q_en[i]) begin
                    it.data = mkword(i, pos[i]);
                    it.qid  = QW'(i);
                    sb.push_back(it);
                    pos[i]++;
                    cnt[i]--;
                    popcnt[i]++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        en_r    = '0;
        out_rdy = 1'b1;
        q_en    = '0;
        q_vld   = '0;
        q_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_qid", out_qid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_q_pop", q_pop, 0);
        rst_n = 1'b1;
        for (int i = 0; i < NQ; i++) begin
            cnt[i]    = 0;
            pos[i]    = 0;
            popcnt[i] = 0;
        end
        sb.delete();
        oq.delete();
        ocyc.delete();
        cyc = 0;
    endtask

    initial begin
        logic [27:0] dexp;
        logic [DW-1:0] held;
        int unsigned c;

        tv[0] = '{en: 4'hF, nw: {8'd0, 8'd0, 8'd0, 8'd3}, n: 8'd3,  gapchk: 8'd3,  exp: 96'h000};
        tv[1] = '{en: 4'hF, nw: {8'd5, 8'd5, 8'd5, 8'd5}, n: 8'd20, gapchk: 8'd16, exp: 96'h00001111222233330123};
        tv[2] = '{en: 4'hA, nw: {8'd2, 8'd2, 8'd2, 8'd2}, n: 8'd4,  gapchk: 8'd2,  exp: 96'h1133};
        tv[3] = '{en: 4'hF, nw: {8'd0, 8'd6, 8'd0, 8'd0}, n: 8'd6,  gapchk: 8'd6,  exp: 96'h222222};

        for (int r = 0; r < 4; r++) begin
            do_reset();
            tag  = 8'(r + 1);
            en_r = tv[r].en;
            for (int i = 0; i < NQ; i++) cnt[i] = 32'(tv[r].nw[i]);
            for (int k = 0; k < 200 && oq.size() < 32'(tv[r].n); k++) begin
                if (k == 0) chk("busy_idle", busy, 0);
                if (k == 1) chk("busy_grant", busy, 1);
                step(1'b1);
            end
            chk("tv_count", oq.size(), 32'(tv[r].n));
            if (oq.size() > 0) chk("tv_latency", ocyc[0], 2);
            for (int j = 0; j < oq.size(); j++) begin
                chk("tv_qid", oq[j], 32'(tv[r].exp[(int'(tv[r].n) - 1 - j)*4 +: 4]));
                if (j > 0 && j < int'(tv[r].gapchk))
                    chk("tv_gap", ocyc[j] - ocyc[j-1], (j % BURST == 0) ? 2 : 1);
            end
            for (int i = 0; i < NQ; i++)
                if (!tv[r].en[i]) chk("tv_disabled_untouched", cnt[i], 32'(tv[r].nw[i]));
        end

        // Backpressure: stall five cycles after the first word of q1.
        do_reset();
        tag  = 8'h50;
        en_r = 4'hF;
        cnt[1] = 8;
        for (c = 0; c < 10 && !out_vld; c++) step(1'b1);
        chk("bp_first_vld", out_vld, 1);
        held = mkword(1, 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            chk("bp_no_pop", last_pop, 0);
            chk("bp_vld_hold", out_vld, 1);
            chk("bp_data_hold", out_data, held);
            chk("bp_busy_hold", busy, 1);
        end
        for (c = 0; c < 100 && oq.size() < 8; c++) step(1'b1);
        chk("bp_count", oq.size(), 8);
        chk("bp_src_empty", cnt[1], 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Disable q2 after two pops; q3 must win over newly enabled q0.
        do_reset();
        tag  = 8'h60;
        en_r = 4'b1100;
        cnt[2] = 6;
        cnt[3] = 3;
        for (c = 0; c < 20 && popcnt[2] < 2; c++) step(1'b1);
        en_r   = 4'b1001;
        cnt[0] = 2;
        for (c = 0; c < 100 && oq.size() < 7; c++) step(1'b1);
        chk("dis_q2_pops", popcnt[2], 2);
        chk("dis_q2_left", cnt[2], 4);
        chk("dis_count", oq.size(), 7);
        dexp = 28'h2233300;
        for (int j = 0; j < oq.size() && j < 7; j++)
            chk("dis_qid", oq[j], 32'(dexp[(6 - j)*4 +: 4]));

        // Wrap: serve q0 once to move ptr to 1, then q3/q0 alternate for 100 bursts.
        do_reset();
        tag  = 8'h70;
        en_r = 4'hF;
        cnt[0] = 1;
        for (c = 0; c < 20 && oq.size() < 1; c++) step(1'b1);
        en_r   = 4'b1001;
        cnt[0] = 200;
        cnt[3] = 200;
        for (c = 0; c < 1000 && oq.size() < 401; c++) step(1'b1);
        chk("wrap_count", oq.size(), 401);
        for (int j = 1; j < oq.size(); j++)
            chk("wrap_qid", oq[j], (((j - 1) / BURST) % 2 == 0) ? 3 : 0);

        // Reset during a stall with a word held on the output.
        do_reset();
        tag  = 8'h80;
        en_r = 4'hF;
        cnt[1] = 6;
        for (c = 0; c < 10 && !out_vld; c++) step(1'b1);
        step(1'b0);
        chk("rst_stall_vld", out_vld, 1);
        rst_n = 1'b0;
        step(1'b0);
        chk("rst_pop_low", last_pop, 0);
        #1;
        chk("rstmid_out_vld", out_vld, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_q_pop", q_pop, 0);
        rst_n = 1'b1;
        sb.delete();
        oq.delete();
        ocyc.delete();
        cnt[0] = 3;
        #1;
        chk("rstmid_idle_pop", q_pop, 0);
        for (c = 0; c < 20 && oq.size() < 1; c++) step(1'b1);
        chk("rstmid_got_word", oq.size(), 1);
        if (oq.size() > 0) chk("rstmid_first_qid", oq[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
